// File: rtl/mem_rd_arbiter.sv
// Two-master (ifu = 0, lsu = 1) read-channel arbiter onto a single memory read port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise lsu has fixed priority on ties.
module mem_rd_arbiter #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ifu_ARVALID,
  output logic          ifu_ARREADY,
  input  logic [DW-1:0] ifu_ARADDR,
  input  logic [2:0]    ifu_ARPORT,
  output logic          ifu_RVALID,
  input  logic          ifu_RREADY,
  output logic [DW-1:0] ifu_RDATA,
  output logic [1:0]    ifu_RRESP,
  input  logic          lsu_ARVALID,
  output logic          lsu_ARREADY,
  input  logic [DW-1:0] lsu_ARADDR,
  input  logic [2:0]    lsu_ARPORT,
  output logic          lsu_RVALID,
  input  logic          lsu_RREADY,
  output logic [DW-1:0] lsu_RDATA,
  output logic [1:0]    lsu_RRESP,
  output logic          mem_ARVALID,
  input  logic          mem_ARREADY,
  output logic [DW-1:0] mem_ARADDR,
  output logic [2:0]    mem_ARPORT,
  input  logic          mem_RVALID,
  output logic          mem_RREADY,
  input  logic [DW-1:0] mem_RDATA,
  input  logic [1:0]    mem_RRESP,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t       state_reg;
  logic [1:0]   gnt_reg;
  logic [1:0]   gnt_next;
`ifdef MEM_ARB_RR_EN
  logic         last_lsu_reg;
`endif

  // Masters gathered into arrays so the per-master routing is one generate body.
  logic [1:0]    m_arvalid;
  logic [1:0]    m_rready;
  logic [DW-1:0] m_araddr [2];
  logic [2:0]    m_arport [2];
  logic [1:0]    m_arready;
  logic [1:0]    m_rvalid;
  logic [DW-1:0] m_rdata [2];
  logic [1:0]    m_rresp [2];
  logic [DW-1:0] addr_masked [2];
  logic [2:0]    port_masked [2];

  logic in_addr;
  logic in_data;
  logic granted_rready;

  assign m_arvalid   = {lsu_ARVALID, ifu_ARVALID};
  assign m_rready    = {lsu_RREADY, ifu_RREADY};
  assign m_araddr[0] = ifu_ARADDR;
  assign m_araddr[1] = lsu_ARADDR;
  assign m_arport[0] = ifu_ARPORT;
  assign m_arport[1] = lsu_ARPORT;

  assign ifu_ARREADY = m_arready[0];
  assign lsu_ARREADY = m_arready[1];
  assign ifu_RVALID  = m_rvalid[0];
  assign lsu_RVALID  = m_rvalid[1];
  assign ifu_RDATA   = m_rdata[0];
  assign lsu_RDATA   = m_rdata[1];
  assign ifu_RRESP   = m_rresp[0];
  assign lsu_RRESP   = m_rresp[1];

  assign in_addr        = (state_reg == ADDR);
  assign in_data        = (state_reg == DATA);
  assign granted_rready = |(gnt_reg & m_rready);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign addr_masked[gi] = (in_addr && gnt_reg[gi]) ? m_araddr[gi] : '0;
      assign port_masked[gi] = (in_addr && gnt_reg[gi]) ? m_arport[gi] : '0;
      assign m_arready[gi]   = in_addr && gnt_reg[gi] && mem_ARREADY;
      assign m_rvalid[gi]    = in_data && gnt_reg[gi] && mem_RVALID;
      assign m_rdata[gi]     = (in_data && gnt_reg[gi]) ? mem_RDATA : '0;
      assign m_rresp[gi]     = (in_data && gnt_reg[gi]) ? mem_RRESP : '0;
    end
  endgenerate

  assign mem_ARVALID = in_addr;
  assign mem_ARADDR  = addr_masked[0] | addr_masked[1];
  assign mem_ARPORT  = port_masked[0] | port_masked[1];
  assign mem_RREADY  = in_data && granted_rready;
  assign gnt         = gnt_reg;

  always_comb begin
    gnt_next = 2'b00;
    case (m_arvalid)
      2'b01: gnt_next = 2'b01;
      2'b10: gnt_next = 2'b10;
`ifdef MEM_ARB_RR_EN
      2'b11: gnt_next = last_lsu_reg ? 2'b01 : 2'b10;
`else
      2'b11: gnt_next = 2'b10;
`endif
      default: gnt_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      gnt_reg      <= 2'b00;
`ifdef MEM_ARB_RR_EN
      last_lsu_reg <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_arvalid) begin
            gnt_reg   <= gnt_next;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (mem_ARREADY) state_reg <= DATA;
        end
        DATA: begin
          if (mem_RVALID && granted_rready) begin
            gnt_reg      <= 2'b00;
`ifdef MEM_ARB_RR_EN
            last_lsu_reg <= gnt_reg[1];
`endif
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
